// File: rtl/modulation_swapchain_pkg.sv
// rtl/modulation_swapchain_pkg.sv - shared settings for the modulation segment swapchain
package modulation_swapchain_pkg;

  // Sequencer states: free-running, waiting for the target period start,
  // counting finite repetitions, and parked after the last repetition.
  typedef enum logic [1:0] {
    RUNNING     = 2'd0,
    WAIT_START  = 2'd1,
    FINITE_LOOP = 2'd2,
    STOPPED     = 2'd3
  } swap_state_e;

  // Repeat count value that selects endless playback.
  localparam logic [31:0] RepInfinite = 32'hFFFFFFFF;

endpackage

// File: rtl/modulation_swapchain_period_start_detect.sv
// rtl/modulation_swapchain_period_start_detect.sv - flags the first cycle of each segment period
module period_start_detect #(
  parameter int WIDTH = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] idx_i,
  output logic             start_o
);

  logic [WIDTH-1:0] prev_q;

  // Remember the previous index so a held zero is not seen as a new period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
    end else begin
      prev_q <= idx_i;
    end
  end

  // A period starts when the index has just moved onto zero.
  assign start_o = (idx_i != prev_q) && (idx_i == '0);

endmodule

// File: rtl/modulation_swapchain.sv
// rtl/modulation_swapchain.sv - selects the active modulation segment and sequences finite repeats
module modulation_swapchain
  import modulation_swapchain_pkg::*;
#(
  parameter int WIDTH = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UPDATE,
  input  logic             REQ_RD_SEGMENT,
  input  logic [31:0]      REP,
  input  logic [WIDTH-1:0] CYCLE_0,
  input  logic [WIDTH-1:0] CYCLE_1,
  input  logic [WIDTH-1:0] IDX_0,
  input  logic [WIDTH-1:0] IDX_1,
  output logic             SEGMENT,
  output logic [WIDTH-1:0] IDX,
  output logic             STOP
);

  swap_state_e      state_q, state_d;
  logic             seg_q, seg_d;
  logic             req_seg_q, req_seg_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             stop_q, stop_d;
  logic [31:0]      loop_cnt_q, loop_cnt_d;
  logic [31:0]      rep_q, rep_d;

  logic             start_0, start_1;
  logic             start_act, start_req;
  logic [WIDTH-1:0] follow_idx, upd_idx, cyc_act;

  period_start_detect #(.WIDTH(WIDTH)) u_start_0 (
    .clk_i   (CLK),
    .rst_i   (RST),
    .idx_i   (IDX_0),
    .start_o (start_0)
  );

  period_start_detect #(.WIDTH(WIDTH)) u_start_1 (
    .clk_i   (CLK),
    .rst_i   (RST),
    .idx_i   (IDX_1),
    .start_o (start_1)
  );

  assign follow_idx = seg_q ? IDX_1 : IDX_0;
  assign upd_idx    = REQ_RD_SEGMENT ? IDX_1 : IDX_0;
  assign cyc_act    = seg_q ? CYCLE_1 : CYCLE_0;
  assign start_act  = seg_q ? start_1 : start_0;
  assign start_req  = req_seg_q ? start_1 : start_0;

  // Next-state selection; UPDATE outranks any period start seen this cycle.
  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    req_seg_d  = req_seg_q;
    idx_d      = follow_idx;
    stop_d     = stop_q;
    loop_cnt_d = loop_cnt_q;
    rep_d      = rep_q;
    if (UPDATE) begin
      stop_d = 1'b0;
      if (REP == RepInfinite) begin
        seg_d   = REQ_RD_SEGMENT;
        idx_d   = upd_idx;
        state_d = RUNNING;
      end else begin
        req_seg_d = REQ_RD_SEGMENT;
        rep_d     = REP;
        state_d   = WAIT_START;
      end
    end else begin
      case (state_q)
        WAIT_START: begin
          if (start_req) begin
            seg_d      = req_seg_q;
            idx_d      = '0;
            loop_cnt_d = '0;
            state_d    = FINITE_LOOP;
          end
        end
        FINITE_LOOP: begin
          if (start_act) begin
            if (loop_cnt_q == rep_q) begin
              state_d = STOPPED;
              stop_d  = 1'b1;
              idx_d   = cyc_act;
            end else begin
              loop_cnt_d = loop_cnt_q + 32'd1;
            end
          end
        end
        STOPPED: begin
          stop_d = 1'b1;
          idx_d  = cyc_act;
        end
        default: ;
      endcase
    end
  end

  // Register the sequencer state and the outputs it drives.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUNNING;
      seg_q      <= 1'b0;
      req_seg_q  <= 1'b0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      loop_cnt_q <= '0;
      rep_q      <= '0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      req_seg_q  <= req_seg_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      loop_cnt_q <= loop_cnt_d;
      rep_q      <= rep_d;
    end
  end

  assign SEGMENT = seg_q;
  assign IDX     = idx_q;
  assign STOP    = stop_q;

endmodule

// File: tb/tb_modulation_swapchain.sv
// tb/tb_modulation_swapchain.sv - self-checking bench for modulation_swapchain
module tb_modulation_swapchain;

  localparam int W = 15;
  localparam logic [31:0] INF = 32'hFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         upd = 1'b0;
  logic         req_seg = 1'b0;
  logic [31:0]  rep = '0;
  logic [W-1:0] cyc0 = W'(999);
  logic [W-1:0] cyc1 = W'(99);
  logic [W-1:0] i0 = '0;
  logic [W-1:0] i1 = '0;
  logic         seg;
  logic [W-1:0] idx;
  logic         stop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  modulation_swapchain #(.WIDTH(W)) dut (
    .CLK            (clk),
    .RST            (rst),
    .UPDATE         (upd),
    .REQ_RD_SEGMENT (req_seg),
    .REP            (rep),
    .CYCLE_0        (cyc0),
    .CYCLE_1        (cyc1),
    .IDX_0          (i0),
    .IDX_1          (i1),
    .SEGMENT        (seg),
    .IDX            (idx),
    .STOP           (stop)
  );

  // Reference model: tracks which segment plays, a pending request, and
  // how many whole periods of a finite request remain.
  int           m_seg = 0;
  int           m_pending = -1;
  longint       m_pend_rep = 0;
  longint       m_left = 0;
  bit           m_stopped = 0;
  logic [W-1:0] m_prev[2];
  logic         exp_seg = 1'b0;
  logic [W-1:0] exp_idx = '0;
  logic         exp_stop = 1'b0;
  bit           exp_valid = 0;

  initial begin
    m_prev[0] = '0;
    m_prev[1] = '0;
  end

  always @(posedge clk) begin
    bit           s[2];
    logic [W-1:0] cur[2];
    logic [W-1:0] cyc[2];
    cur[0] = i0; cur[1] = i1;
    cyc[0] = cyc0; cyc[1] = cyc1;
    s[0] = (cur[0] != m_prev[0]) && (cur[0] == 0);
    s[1] = (cur[1] != m_prev[1]) && (cur[1] == 0);
    if (rst) begin
      m_seg = 0; m_pending = -1; m_left = 0; m_stopped = 0; m_pend_rep = 0;
      exp_idx = '0;
    end else if (upd) begin
      m_stopped = 0;
      m_left = 0;
      if (rep == INF) begin
        m_seg = int'(req_seg);
        m_pending = -1;
      end else begin
        m_pending = int'(req_seg);
        m_pend_rep = longint'(rep);
      end
      exp_idx = cur[m_seg];
    end else if (m_pending >= 0) begin
      if (s[m_pending]) begin
        m_seg = m_pending;
        m_pending = -1;
        m_left = m_pend_rep + 1;
        exp_idx = '0;
      end else begin
        exp_idx = cur[m_seg];
      end
    end else if (m_stopped) begin
      exp_idx = cyc[m_seg];
    end else if (m_left > 0 && s[m_seg]) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_stopped = 1;
        exp_idx = cyc[m_seg];
      end else begin
        exp_idx = cur[m_seg];
      end
    end else begin
      exp_idx = cur[m_seg];
    end
    exp_seg  = (m_seg != 0);
    exp_stop = m_stopped;
    m_prev[0] = rst ? '0 : cur[0];
    m_prev[1] = rst ? '0 : cur[1];
    exp_valid = 1;
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      tests++;
      if (seg !== exp_seg || idx !== exp_idx || stop !== exp_stop) begin
        fails++;
        $display("FAIL model t=%0t seg=%0d/%0d idx=%0d/%0d stop=%0d/%0d (actual/required)",
                 $time, seg, exp_seg, idx, exp_idx, stop, exp_stop);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Modulation timer emulation: both indices step every div cycles.
  int div = 1;
  int tcnt = 0;
  bit hold = 0;

  task automatic tick();
    if (hold) return;
    tcnt++;
    if (tcnt >= div) begin
      tcnt = 0;
      i0 = (i0 >= cyc0) ? '0 : i0 + W'(1);
      i1 = (i1 >= cyc1) ? '0 : i1 + W'(1);
    end
  endtask

  // Apply one cycle of inputs at a falling edge, then wait for the next one.
  task automatic drive(input bit u, input bit s, input logic [31:0] r);
    upd = u; req_seg = s; rep = r;
    tick();
    @(negedge clk);
    upd = 1'b0;
  endtask

  logic [W-1:0] sent;
  int play;
  int guard;

  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (3) drive(0, 0, 0);
    check("reset_seg", seg, 0);
    check("reset_idx", idx, 0);
    check("reset_stop", stop, 0);

    // Free running on segment 0, slow timer.
    rst = 1'b0; div = 8;
    repeat (20) drive(0, 0, 0);
    sent = i0;
    hold = 1;
    drive(0, 0, 0);
    check("track_idx0", idx, sent);
    check("track_seg0", seg, 0);

    // Infinite switch takes effect next cycle with no wait.
    cyc1 = W'(999); i1 = W'(437);
    drive(1, 1, INF);
    check("inf_switch_seg", seg, 1);
    check("inf_switch_idx", idx, 437);

    // Finite REP=2 on segment 1 with a 100-sample period.
    drive(1, 0, INF);
    hold = 0; div = 1; cyc1 = W'(99); i1 = W'(50);
    drive(1, 1, 2);
    check("finite_wait_seg", seg, 0);
    guard = 0;
    while (seg == 1'b0 && guard < 200) begin drive(0, 0, 0); guard++; end
    check("finite_enter_idx", idx, 0);
    play = 0; guard = 0;
    while (stop == 1'b0 && guard < 1000) begin
      if (seg == 1'b1) play++;
      drive(0, 0, 0); guard++;
    end
    check("rep2_play_cycles", play, 300);
    check("rep2_stop_idx", idx, 99);
    repeat (5) drive(0, 0, 0);
    check("rep2_hold_idx", idx, 99);
    check("rep2_hold_stop", stop, 1);

    // REP=0 plays one period, then infinite update clears STOP.
    drive(1, 1, 0);
    guard = 0;
    while (seg == 1'b1 && idx != 0 && guard < 200) begin drive(0, 0, 0); guard++; end
    play = 0; guard = 0;
    while (stop == 1'b0 && guard < 400) begin drive(0, 0, 0); play++; guard++; end
    check("rep0_play_cycles", play, 100);
    drive(1, 0, INF);
    check("rep0_clear_stop", stop, 0);
    check("rep0_clear_seg", seg, 0);

    // Abort a pending switch with an infinite update to segment 0.
    drive(1, 1, 5);
    repeat (3) drive(0, 0, 0);
    drive(1, 0, INF);
    check("abort_seg", seg, 0);
    repeat (150) drive(0, 0, 0);
    check("abort_stays_seg0", seg, 0);

    // Update on the same cycle as the target wrap wins.
    hold = 1; i1 = W'(98);
    drive(1, 1, 0);
    i1 = W'(99);
    drive(0, 0, 0);
    i1 = '0;
    drive(1, 0, INF);
    check("upd_beats_wrap_seg", seg, 0);
    repeat (3) drive(0, 0, 0);
    check("upd_beats_wrap_later", seg, 0);

    // Reset in the middle of a finite loop.
    hold = 0; cyc1 = W'(9); i1 = W'(3);
    drive(1, 1, 3);
    guard = 0;
    while (seg == 1'b0 && guard < 50) begin drive(0, 0, 0); guard++; end
    repeat (12) drive(0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0);
    check("rst_mid_seg", seg, 0);
    check("rst_mid_idx", idx, 0);
    check("rst_mid_stop", stop, 0);
    rst = 1'b0;
    sent = i0;
    hold = 1;
    drive(0, 0, 0);
    check("rst_first_idx0", idx, sent);
    hold = 0;

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 4000; n++) begin
      bit u;
      bit s;
      logic [31:0] r;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) cyc0 = W'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) cyc1 = W'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) div = $urandom_range(1, 3);
      hold = ($urandom_range(0, 19) == 0);
      u = ($urandom_range(0, 29) == 0);
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0, 1:    r = INF;
        2:       r = 32'hFFFFFFFE;
        default: r = 32'($urandom_range(0, 3));
      endcase
      drive(u, s, r);
    end
    rst = 1'b0; hold = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/modulation_swapchain.md
MODULATION_SWAPCHAIN -- requirements
Module: modulation_swapchain

Interface
REQ-001 SHALL have parameter WIDTH, default 15, the index and cycle width.
REQ-002 SHALL have port CLK, input, 1, the 20.48 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port UPDATE, input, 1, a one-cycle pulse meaning that new segment settings are valid.
REQ-005 SHALL have port REQ_RD_SEGMENT, input, 1, the requested segment; sampled on UPDATE.
REQ-006 SHALL have port REP, input, 32, the repeat count; 32'hFFFFFFFF means infinite; sampled on UPDATE.
REQ-007 SHALL have ports CYCLE_0 and CYCLE_1, input, WIDTH each, the last index of each segment.
REQ-008 SHALL have ports IDX_0 and IDX_1, input, WIDTH each, the per-segment indices from the modulation timer.
REQ-009 SHALL have port SEGMENT, output, 1, the active segment.
REQ-010 SHALL have port IDX, output, WIDTH, the index into the active segment's sample memory.
REQ-011 SHALL have port STOP, output, 1; high means a finite repetition has completed.

Function
REQ-012 SHALL register IDX: IDX = IDX_SEGMENT of the previous cycle, so latency is 1 cycle, except as stated in REQ-020.
REQ-013 SHALL detect a period start per segment when IDX_n differs from its registered previous value and IDX_n == 0.
REQ-014 SHALL implement states RUNNING, WAIT_START, FINITE_LOOP and STOPPED.
REQ-015 On UPDATE with REP == 32'hFFFFFFFF, SHALL, on the next cycle:
- set SEGMENT = REQ_RD_SEGMENT
- clear STOP
- enter RUNNING
REQ-016 On UPDATE with finite REP, SHALL:
- latch the requested segment and REP
- enter WAIT_START
- leave SEGMENT and IDX unchanged, still following the old segment
REQ-017 In WAIT_START, on a period start of the latched segment, SHALL, in the same registered update:
- set SEGMENT to the latched segment
- set IDX = 0
- clear the loop counter
- enter FINITE_LOOP
REQ-018 In FINITE_LOOP, each period start of the active segment SHALL increment the 32-bit loop counter.
REQ-019 In FINITE_LOOP, a period start with loop counter == latched REP SHALL enter STOPPED instead of incrementing, so that REP = 0 plays exactly one period.
REQ-020 In STOPPED, SHALL drive STOP = 1 and hold IDX at CYCLE_SEGMENT, ignoring IDX_n.
- STOP asserts on the same cycle IDX would otherwise have shown 0.
REQ-021 UPDATE SHALL be honoured in every state, including mid-WAIT_START and mid-FINITE_LOOP; it aborts the current sequence and applies REQ-015 or REQ-016.
REQ-022 UPDATE requesting the already-active segment SHALL behave identically to a switch; a finite request still waits for the next period start.
REQ-023 A simultaneous UPDATE and period start SHALL give UPDATE priority; the period start is ignored.
REQ-024 If CYCLE_n == 0, the segment has no period-start events; WAIT_START for it persists until the next UPDATE.
REQ-025 The loop counter SHALL not wrap; REP is at most 32'hFFFFFFFE in finite mode.

Reset
REQ-026 While RST is high, SHALL set SEGMENT = 0, IDX = 0, STOP = 0, state RUNNING, loop counter 0, latched REP 0, and previous-index registers 0.
REQ-027 Reset mid-sequence SHALL discard the pending switch; after RST falls, the first output is IDX_0 with 1-cycle latency.

Structure
REQ-028 SHALL place in the shared settings package:
- the state enum (RUNNING, WAIT_START, FINITE_LOOP, STOPPED)
- the constant RepInfinite = 32'hFFFFFFFF
REQ-029 SHALL be a single module, with one natural sub-module period_start_detect, instantiated twice, one per segment.

Verification
REQ-030 Reset, CYCLE_0 = 999, FREQ_DIV 8 -> IDX tracks IDX_0 one cycle late, SEGMENT = 0, STOP = 0.
REQ-031 UPDATE with REQ_RD_SEGMENT = 1 and REP = FFFFFFFF while IDX_1 = 437 -> SEGMENT = 1 next cycle and IDX = 437, no wait.
REQ-032 UPDATE with segment 1, REP = 2, CYCLE_1 = 99:
- IDX keeps following IDX_0 until IDX_1 wraps 99->0
- then SEGMENT = 1 and three full periods play
- on the fourth wrap, STOP = 1 and IDX = 99 held
REQ-033 REP = 0 -> exactly one period, then STOP = 1; a following UPDATE with REP = FFFFFFFF clears STOP within 1 cycle.
REQ-034 Second UPDATE in WAIT_START, to segment 0 with REP = FFFFFFFF -> immediate SEGMENT = 0 and the pending switch is discarded; UPDATE on the same cycle as a wrap -> UPDATE wins.
REQ-035 RST asserted in FINITE_LOOP with loop counter 1 -> next cycle SEGMENT = 0, IDX = 0, STOP = 0, state RUNNING.
